// File: rtl/expand_a_sink_if.sv
// rtl/expand_a_sink_if.sv - expand_a_sink control, sampler and RAM-write signal bundle
interface expand_a_sink_if;
    logic        i_start;
    logic [3:0]  i_k;
    logic [3:0]  i_l;
    logic        o_samp_start;
    logic [7:0]  o_samp_row;
    logic [7:0]  o_samp_column;
    logic        i_coeff_valid;
    logic [22:0] i_coeff_data;
    logic        i_samp_done;
    logic        o_wr_en;
    logic [13:0] o_wr_addr;
    logic [22:0] o_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    modport master (
        output i_start, i_k, i_l, i_coeff_valid, i_coeff_data, i_samp_done,
        input  o_samp_start, o_samp_row, o_samp_column, o_wr_en, o_wr_addr,
               o_wr_data, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_k, i_l, i_coeff_valid, i_coeff_data, i_samp_done,
        output o_samp_start, o_samp_row, o_samp_column, o_wr_en, o_wr_addr,
               o_wr_data, o_busy, o_done, o_err
    );
endinterface

// File: rtl/expand_a_sink.sv
// rtl/expand_a_sink.sv - sequences a K x L matrix expansion through a rejection sampler into RAM
module expand_a_sink (
    input  logic           clk,
    input  logic           rst_n,
    expand_a_sink_if.slave bus
);
    localparam logic [22:0] Q = 23'd8380417;

    typedef enum logic [2:0] {
        IDLE, LAUNCH, COLLECT, WAIT_DONE, NEXT, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  k_lat, l_lat;
    logic [2:0]  row, col;
    logic [7:0]  idx;
    logic        err;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [22:0] wr_data;

    logic range_bad, coeff_ok, col_last, row_last;

    assign range_bad = (bus.i_k == 4'd0) || (bus.i_k > 4'd8) ||
                       (bus.i_l == 4'd0) || (bus.i_l > 4'd8);
    assign coeff_ok  = bus.i_coeff_valid && (bus.i_coeff_data < Q);
    assign col_last  = ({1'b0, col} == (l_lat - 4'd1));
    assign row_last  = ({1'b0, row} == (k_lat - 4'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.i_start) state_nxt = range_bad ? DONE : LAUNCH;
            LAUNCH:    state_nxt = COLLECT;
            // A stale done from the previous polynomial is deliberately not looked at here.
            COLLECT:   if (coeff_ok && (idx == 8'hFF)) state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.i_samp_done) state_nxt = NEXT;
            NEXT:      state_nxt = (col_last && row_last) ? DONE : LAUNCH;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_lat   <= 4'd0;
            l_lat   <= 4'd0;
            row     <= 3'd0;
            col     <= 3'd0;
            idx     <= 8'd0;
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= 14'd0;
            wr_data <= 23'd0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        k_lat <= bus.i_k;
                        l_lat <= bus.i_l;
                        row   <= 3'd0;
                        col   <= 3'd0;
                        idx   <= 8'd0;
                        err   <= range_bad;
                    end else if (bus.i_coeff_valid) begin
                        err <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (coeff_ok) begin
                        wr_en   <= 1'b1;
                        wr_data <= bus.i_coeff_data;
                        wr_addr <= {row, col, idx};
                        idx     <= idx + 8'd1;
                    end else if (bus.i_coeff_valid) begin
                        err <= 1'b1;
                    end
                end
                NEXT: begin
                    if (bus.i_coeff_valid) err <= 1'b1;
                    if (!col_last) begin
                        col <= col + 3'd1;
                    end else if (!row_last) begin
                        col <= 3'd0;
                        row <= row + 3'd1;
                    end
                end
                LAUNCH, WAIT_DONE, DONE: begin
                    if (bus.i_coeff_valid) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_samp_start  = (state == LAUNCH);
    assign bus.o_samp_row    = {5'd0, row};
    assign bus.o_samp_column = {5'd0, col};
    assign bus.o_wr_en       = wr_en;
    assign bus.o_wr_addr     = wr_addr;
    assign bus.o_wr_data     = wr_data;
    assign bus.o_busy        = (state == LAUNCH) || (state == COLLECT) ||
                               (state == WAIT_DONE) || (state == NEXT);
    assign bus.o_done        = (state == DONE);
    assign bus.o_err         = err;
endmodule

// File: tb/tb_expand_a_sink.sv
// tb/tb_expand_a_sink.sv - randomized sampler model and write scoreboard for expand_a_sink
module tb_expand_a_sink;
    localparam int Q = 8380417;

    typedef struct {
        logic [3:0] k;
        logic [3:0] l;
        bit         inject;
        bit         stale;
        bit         extra;
        bit         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    expand_a_sink_if bus ();
    expand_a_sink dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int nwrites, nlaunch, ndone, cur_l;
    int smp_sent;
    bit inject_pending, stale_mode, extra_mode;
    logic [22:0] exp_data[$];
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected write order is derived from the running write count alone.
    always @(negedge clk) begin
        if (bus.o_wr_en) begin
            check("wr_addr", {18'd0, bus.o_wr_addr},
                  ((nwrites / (256 * cur_l)) << 11) | (((nwrites / 256) % cur_l) << 8) | (nwrites % 256));
            if (exp_data.size() > 0) check("wr_data", {9'd0, bus.o_wr_data}, {9'd0, exp_data.pop_front()});
            else                     check("wr_unexpected", {31'd0, bus.o_wr_en}, 0);
            nwrites++;
        end
        if (bus.o_samp_start) begin
            check("launch_row", {24'd0, bus.o_samp_row},    nlaunch / cur_l);
            check("launch_col", {24'd0, bus.o_samp_column}, nlaunch % cur_l);
            nlaunch++;
        end
        if (bus.o_done) ndone++;
    end

    always begin
        @(negedge clk);
        if (rst_n && bus.o_samp_start) begin
            smp_sent = 0;
            if (!stale_mode) bus.i_samp_done = 1'b0;
            while (smp_sent < 256 && rst_n) begin
                @(negedge clk);
                if (!rst_n) break;
                if ($urandom_range(0, 3) == 0) begin
                    bus.i_coeff_valid = 1'b0;
                end else if (inject_pending && smp_sent == 10) begin
                    bus.i_coeff_valid = 1'b1;
                    bus.i_coeff_data  = 23'(Q + $urandom_range(0, 1000));
                    inject_pending    = 1'b0;
                end else begin
                    bus.i_coeff_valid = 1'b1;
                    bus.i_coeff_data  = 23'($urandom_range(0, Q - 1));
                    exp_data.push_back(bus.i_coeff_data);
                    smp_sent++;
                end
                if (stale_mode && smp_sent == 20) bus.i_samp_done = 1'b0;
            end
            if (rst_n) begin
                @(negedge clk);
                if (extra_mode) begin
                    bus.i_coeff_valid = 1'b1;
                    bus.i_coeff_data  = 23'($urandom_range(0, Q - 1));
                    @(negedge clk);
                end
                bus.i_coeff_valid = 1'b0;
                repeat (2) @(negedge clk);
                bus.i_samp_done = 1'b1;
            end
            bus.i_coeff_valid = 1'b0;
        end
    end

    task automatic clear_model(input int l);
        nwrites = 0;
        nlaunch = 0;
        ndone   = 0;
        cur_l   = (l == 0) ? 1 : l;
        exp_data.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        bit bad;
        bad = (v.k == 0) || (v.k > 8) || (v.l == 0) || (v.l > 8);
        clear_model(int'(v.l));
        inject_pending = v.inject;
        stale_mode     = v.stale;
        extra_mode     = v.extra;
        @(negedge clk);
        bus.i_k = v.k; bus.i_l = v.l; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        if (bad) begin
            check("bad_done_pulse", {31'd0, bus.o_done}, 1);
            check("bad_err", {31'd0, bus.o_err}, 1);
            repeat (5) @(negedge clk);
            check("bad_launches", nlaunch, 0);
            check("bad_writes", nwrites, 0);
            check("bad_done_count", ndone, 1);
        end else begin
            check("busy_after_start", {31'd0, bus.o_busy}, 1);
            repeat (50) @(negedge clk);
            bus.i_k = 4'd0; bus.i_l = 4'd0; bus.i_start = 1'b1;
            @(negedge clk);
            bus.i_start = 1'b0; bus.i_k = v.k; bus.i_l = v.l;
            cyc = 0;
            while (!bus.o_done && cyc < 256 * v.k * v.l * 3 + 500) begin
                @(negedge clk);
                cyc++;
            end
            check("done_seen", {31'd0, bus.o_done}, 1);
            check("busy_at_done", {31'd0, bus.o_busy}, 0);
            check("err_at_done", {31'd0, bus.o_err}, {31'd0, v.exp_err});
            repeat (3) @(negedge clk);
            check("done_count", ndone, 1);
            check("write_count", nwrites, 256 * v.k * v.l);
            check("launch_count", nlaunch, v.k * v.l);
            check("data_left", exp_data.size(), 0);
            check("busy_after_done", {31'd0, bus.o_busy}, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_samp_start"}, {31'd0, bus.o_samp_start}, 0);
        check({tag, "_samp_row"},   {24'd0, bus.o_samp_row}, 0);
        check({tag, "_samp_col"},   {24'd0, bus.o_samp_column}, 0);
        check({tag, "_wr_en"},      {31'd0, bus.o_wr_en}, 0);
        check({tag, "_wr_addr"},    {18'd0, bus.o_wr_addr}, 0);
        check({tag, "_wr_data"},    {9'd0, bus.o_wr_data}, 0);
        check({tag, "_busy"},       {31'd0, bus.o_busy}, 0);
        check({tag, "_done"},       {31'd0, bus.o_done}, 0);
        check({tag, "_err"},        {31'd0, bus.o_err}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.i_start = 1'b0; bus.i_k = 4'd0; bus.i_l = 4'd0;
        bus.i_coeff_valid = 1'b0; bus.i_coeff_data = 23'd0; bus.i_samp_done = 1'b0;
        inject_pending = 1'b0; stale_mode = 1'b0; extra_mode = 1'b0;
        clear_model(1);

        //          k     l     inj stale extra exp_err
        vecs[0]  = '{4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{4'd2, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{4'd1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{4'd9, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{4'd8, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Reset in the middle of the first polynomial, then restart from scratch.
        clear_model(1);
        inject_pending = 1'b0; stale_mode = 1'b0; extra_mode = 1'b0;
        @(negedge clk);
        bus.i_k = 4'd1; bus.i_l = 4'd1; bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        cyc = 0;
        while (nwrites < 100 && cyc < 2000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("rst_reached_100_writes", nwrites, 100);
        #1 rst_n = 1'b0;
        #1 check_all_zero("midrun_rst");
        repeat (3) @(negedge clk);
        clear_model(1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_writes", nwrites, 0);
        check("post_rst_busy", {31'd0, bus.o_busy}, 0);
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/expand_a_sink.md
EXPAND_A_SINK -- requirements
Module: expand_a_sink

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 i_start  input  1  one-cycle pulse; begins expansion of a K x L matrix.
REQ-004 i_k  input  4  row count K; legal range 1..8.
REQ-005 i_l  input  4  column count L; legal range 1..8.
REQ-006 o_samp_start  output  1  one-cycle start pulse to the rejection sampler.
REQ-007 o_samp_row  output  8  row index to the sampler; held stable from launch until the polynomial completes.
REQ-008 o_samp_column  output  8  column index to the sampler; held stable like o_samp_row.
REQ-009 i_coeff_valid  input  1  sampler coefficient strobe, one cycle per coefficient.
REQ-010 i_coeff_data  input  23  sampler coefficient value.
REQ-011 i_samp_done  input  1  sampler level done flag; stays high until the sampler's next start.
REQ-012 o_wr_en  output  1  polynomial RAM write strobe.
REQ-013 o_wr_addr  output  14  RAM address {row[2:0], col[2:0], idx[7:0]}.
REQ-014 o_wr_data  output  23  RAM write data.
REQ-015 o_busy  output  1  high from an accepted start until o_done.
REQ-016 o_done  output  1  one-cycle pulse when the matrix is complete.
REQ-017 o_err  output  1  sticky protocol/range error; cleared by the next accepted start.

Function
REQ-018 States: IDLE, LAUNCH, COLLECT, WAIT_DONE, NEXT, DONE.
REQ-019 IDLE: i_start accepted only here. On accept: latch K/L, row=0, col=0, idx=0, clear o_err, o_busy=1, go LAUNCH.
REQ-020 Start with K or L outside 1..8: o_err=1, o_done pulse on the next cycle, no sampler launch, return to IDLE.
REQ-021 i_start while o_busy=1 is ignored; no error is raised.
REQ-022 LAUNCH: o_samp_start=1 for exactly one cycle, with o_samp_row/o_samp_column already equal to the current row/col; next state COLLECT.
REQ-023 COLLECT: each i_coeff_valid with data < 8380417 produces, on the next cycle:
  - o_wr_en=1;
  - o_wr_data equal to that data;
  - o_wr_addr={row,col,idx};
  - then idx increments by 1.
REQ-024 COLLECT, coefficient >= 8380417: no write, idx unchanged, o_err=1.
REQ-025 On the write of idx=255, idx wraps to 0 and the state goes to WAIT_DONE.
REQ-026 i_samp_done is ignored in LAUNCH and COLLECT, because a stale done from the previous polynomial may still be high.
REQ-027 WAIT_DONE: i_samp_done=1 moves to NEXT. Any i_coeff_valid here sets o_err=1 and the data is discarded.
REQ-028 NEXT advances the indices:
  - if col<L-1: col+1, go LAUNCH;
  - else if row<K-1: col=0, row+1, go LAUNCH;
  - else go DONE.
REQ-029 DONE: o_done=1 for one cycle, o_busy=0, then IDLE.
REQ-030 i_coeff_valid in IDLE, LAUNCH or DONE sets o_err=1 and the data is discarded.
REQ-031 o_samp_row/o_samp_column are zero-extended 3-bit counters: upper 5 bits always 0.
REQ-032 Total writes per run = 256*K*L when no range errors occur; every address in the K x L region is written exactly once, in ascending idx order.

Reset
REQ-033 rst_n low, at any time including mid-COLLECT, forces:
  - state IDLE;
  - all outputs 0: o_samp_start, o_samp_row, o_samp_column, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_err;
  - row/col/idx counters 0.
REQ-034 After reset release, no write occurs until a new accepted i_start.

Verification
REQ-035 K=1, L=1; model sampler sends 256 coefficients 0..255, then done -> 256 writes, addresses 0x0000..0x00FF, data=idx, one o_samp_start, o_done once, o_err=0.
REQ-036 K=4, L=4 -> 16 launches in order (0,0),(0,1)..(3,3); first write of poly (1,2) at addr 0x0A00; 4096 writes total; o_done then o_busy=0.
REQ-037 Coefficient 8380417 injected at idx 10 -> no write for it, o_err=1, next valid coefficient written at idx 10, run still completes.
REQ-038 Stale i_samp_done=1 held through LAUNCH and early COLLECT -> no premature NEXT; the 257th coefficient arriving in WAIT_DONE sets o_err.
REQ-039 i_k=0 or i_l=9 -> o_err=1, o_done pulse, o_samp_start never asserted.
REQ-040 rst_n asserted after 100 writes of poly (0,0) -> all outputs 0 immediately; a restart rewrites from addr 0x0000.
